// File: rtl/link_pkg.sv
// Shared link constants, header field helpers, deframer state encoding and block word payload.
package link_pkg;

    localparam int unsigned DATA_W       = 16;
    localparam int unsigned CHAN_W       = 4;
    localparam int unsigned LEN_W        = 8;
    localparam int unsigned HDR_CHAN_LSB = 8;
    localparam int unsigned HDR_CHAN_MSB = 11;
    localparam int unsigned HDR_LEN_LSB  = 0;
    localparam int unsigned HDR_LEN_MSB  = 7;
    localparam int unsigned LOCK_COMMAS  = 4;
    localparam int unsigned LOCK_CNT_W   = 3;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned TRIG_CNT_W   = 32;

    localparam logic [DATA_W-1:0] CH_COMMA = 16'h00BC;
    localparam logic [DATA_W-1:0] CH_TRIG  = 16'h801C;

    typedef enum logic [2:0] {
        ST_UNLOCK = 3'd0,
        ST_IDLE   = 3'd1,
        ST_DATA   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DRAIN  = 3'd4
    } state_e;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } blk_word_t;

    function automatic logic [CHAN_W-1:0] hdr_chan(input logic [DATA_W-1:0] w);
        return w[HDR_CHAN_MSB:HDR_CHAN_LSB];
    endfunction

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] w);
        return w[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low reset.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/link_deframer.sv
// Link receive deframer: comma lock, trigger extraction, block framing and link-health counters.
module link_deframer
    import link_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     din,
    input  logic                  kchar,
    output logic                  trig,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  blk_end,
    output logic                  blk_err,
    output logic [CHAN_W-1:0]     blk_chan,
    output logic                  link_up,
    output logic [TRIG_CNT_W-1:0] trig_cnt,
    output logic [CNT_W-1:0]      blk_cnt,
    output logic [CNT_W-1:0]      err_cnt
);

    logic [DATA_W-1:0]     din_q;
    logic                  kchar_q;
    state_e                state_q, state_d;
    logic [LOCK_CNT_W-1:0] commas_q, commas_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic                  link_up_q, link_up_d;
    logic                  trig_q, trig_d;
    logic                  valid_q, valid_d;
    blk_word_t             word_q, word_d;
    logic                  blk_end_q, blk_end_d;
    logic                  blk_err_q, blk_err_d;
    logic [CHAN_W-1:0]     chan_q, chan_d;
    logic [TRIG_CNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic                  blk_inc, err_inc;
    logic                  is_comma, is_trig, is_bad, is_data;

    assign is_comma = kchar_q && (din_q == CH_COMMA);
    assign is_trig  = kchar_q && (din_q == CH_TRIG);
    assign is_bad   = kchar_q && !is_comma && !is_trig;
    assign is_data  = !kchar_q;

    // Decode of the word captured on the previous edge; triggers never disturb the block state.
    always_comb begin
        state_d    = state_q;
        commas_d   = commas_q;
        rem_d      = rem_q;
        link_up_d  = link_up_q;
        trig_d     = is_trig;
        trig_cnt_d = trig_cnt_q + TRIG_CNT_W'(is_trig);
        valid_d    = 1'b0;
        word_d     = '0;
        blk_end_d  = 1'b0;
        blk_err_d  = 1'b0;
        chan_d     = chan_q;
        blk_inc    = 1'b0;
        err_inc    = 1'b0;

        if (is_bad) begin
            err_inc   = 1'b1;
            link_up_d = 1'b0;
            commas_d  = '0;
            state_d   = ST_UNLOCK;
            if (state_q == ST_DATA) begin
                blk_end_d = 1'b1;
                blk_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_UNLOCK: begin
                    if (is_comma) begin
                        if (commas_q == LOCK_CNT_W'(LOCK_COMMAS - 1)) begin
                            commas_d  = '0;
                            link_up_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            commas_d = commas_q + LOCK_CNT_W'(1);
                        end
                    end else if (is_data) begin
                        commas_d = '0;
                    end
                end
                ST_IDLE: begin
                    if (is_data) begin
                        valid_d     = 1'b1;
                        word_d.sop  = 1'b1;
                        word_d.data = din_q;
                        chan_d      = hdr_chan(din_q);
                        rem_d       = hdr_len(din_q);
                        if (hdr_len(din_q) == '0) begin
                            word_d.eop = 1'b1;
                            blk_end_d  = 1'b1;
                            blk_inc    = 1'b1;
                            state_d    = ST_GAP;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (is_data) begin
                        valid_d     = 1'b1;
                        word_d.data = din_q;
                        rem_d       = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            word_d.eop = 1'b1;
                            blk_end_d  = 1'b1;
                            blk_inc    = 1'b1;
                            state_d    = ST_GAP;
                        end
                    end else if (is_comma) begin
                        blk_end_d = 1'b1;
                        blk_err_d = 1'b1;
                        err_inc   = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (is_comma) begin
                        state_d = ST_IDLE;
                    end else if (is_data) begin
                        err_inc = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (is_comma) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_UNLOCK;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_q      <= '0;
            kchar_q    <= 1'b0;
            state_q    <= ST_UNLOCK;
            commas_q   <= '0;
            rem_q      <= '0;
            link_up_q  <= 1'b0;
            trig_q     <= 1'b0;
            trig_cnt_q <= '0;
            valid_q    <= 1'b0;
            word_q     <= '0;
            blk_end_q  <= 1'b0;
            blk_err_q  <= 1'b0;
            chan_q     <= '0;
        end else begin
            din_q      <= din;
            kchar_q    <= kchar;
            state_q    <= state_d;
            commas_q   <= commas_d;
            rem_q      <= rem_d;
            link_up_q  <= link_up_d;
            trig_q     <= trig_d;
            trig_cnt_q <= trig_cnt_d;
            valid_q    <= valid_d;
            word_q     <= word_d;
            blk_end_q  <= blk_end_d;
            blk_err_q  <= blk_err_d;
            chan_q     <= chan_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_blk_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (blk_inc),
        .count (blk_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .count (err_cnt)
    );

    assign trig      = trig_q;
    assign out_valid = valid_q;
    assign out_data  = word_q.data;
    assign out_sop   = word_q.sop;
    assign out_eop   = word_q.eop;
    assign blk_end   = blk_end_q;
    assign blk_err   = blk_err_q;
    assign blk_chan  = chan_q;
    assign link_up   = link_up_q;
    assign trig_cnt  = trig_cnt_q;

endmodule
